// File: rtl/morse_key_decoder.sv
// Morse key decoder: times marks/spaces on a debounced key and emits ASCII characters and word gaps.
// Optional build macro MORSE_LED_EN adds led_dot/led_dash element indicators.
module morse_key_decoder #(
  parameter int TICKS_PER_UNIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       char_ready,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       sym_err,
  output logic       overflow
`ifdef MORSE_LED_EN
  ,
  output logic       led_dot,
  output logic       led_dash
`endif
);

  localparam logic [15:0] DASH_MIN = 16'(2 * TICKS_PER_UNIT);
  localparam logic [15:0] CHAR_GAP = 16'(3 * TICKS_PER_UNIT);
  localparam logic [15:0] WORD_GAP = 16'(7 * TICKS_PER_UNIT);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [4:0]  pat;
  logic [2:0]  len;
  logic        overlong;
  logic        pending;
  logic        elem_end, char_end, word_end, complete;
  logic [7:0]  decoded, new_code;
  logic        new_err;

  // Index is {length, pattern}; the first element sits in the highest used bit.
  function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] p);
    case ({n, p})
      8'b010_00001: decode = 8'h41; // A .-
      8'b100_01000: decode = 8'h42; // B
      8'b100_01010: decode = 8'h43; // C
      8'b011_00100: decode = 8'h44; // D
      8'b001_00000: decode = 8'h45; // E
      8'b100_00010: decode = 8'h46; // F
      8'b011_00110: decode = 8'h47; // G
      8'b100_00000: decode = 8'h48; // H
      8'b010_00000: decode = 8'h49; // I
      8'b100_00111: decode = 8'h4A; // J
      8'b011_00101: decode = 8'h4B; // K
      8'b100_00100: decode = 8'h4C; // L
      8'b010_00011: decode = 8'h4D; // M
      8'b010_00010: decode = 8'h4E; // N
      8'b011_00111: decode = 8'h4F; // O
      8'b100_00110: decode = 8'h50; // P
      8'b100_01101: decode = 8'h51; // Q
      8'b011_00010: decode = 8'h52; // R
      8'b011_00000: decode = 8'h53; // S
      8'b001_00001: decode = 8'h54; // T
      8'b011_00001: decode = 8'h55; // U
      8'b100_00001: decode = 8'h56; // V
      8'b011_00011: decode = 8'h57; // W
      8'b100_01001: decode = 8'h58; // X
      8'b100_01011: decode = 8'h59; // Y
      8'b100_01100: decode = 8'h5A; // Z
      8'b101_11111: decode = 8'h30;
      8'b101_01111: decode = 8'h31;
      8'b101_00111: decode = 8'h32;
      8'b101_00011: decode = 8'h33;
      8'b101_00001: decode = 8'h34;
      8'b101_00000: decode = 8'h35;
      8'b101_10000: decode = 8'h36;
      8'b101_11000: decode = 8'h37;
      8'b101_11100: decode = 8'h38;
      8'b101_11110: decode = 8'h39;
      default:      decode = 8'h3F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (key_in) state_nx = MARK;
      MARK:    if (!key_in) state_nx = SPACE;
      SPACE: begin
        if (key_in)               state_nx = MARK;
        else if (cnt == WORD_GAP) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    elem_end = 1'b0;
    char_end = 1'b0;
    word_end = 1'b0;
    case (state)
      MARK:  elem_end = !key_in;
      SPACE: begin
        char_end = (cnt == CHAR_GAP) && (len != 3'd0);
        word_end = (cnt == WORD_GAP) && pending;
      end
      default: ;
    endcase
    complete = char_end || word_end;
    decoded  = decode(len, pat);
    if (word_end) begin
      new_code = 8'h20;
      new_err  = 1'b0;
    end else if (overlong) begin
      new_code = 8'h3F;
      new_err  = 1'b1;
    end else begin
      new_code = decoded;
      new_err  = (decoded == 8'h3F);
    end
  end

  // Element timing and character assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 16'd0;
      pat      <= 5'd0;
      len      <= 3'd0;
      overlong <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (state_nx != state)  cnt <= 16'd1;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;

      if (char_end) begin
        pat      <= 5'd0;
        len      <= 3'd0;
        overlong <= 1'b0;
      end else if (elem_end) begin
        if (len == 3'd5) begin
          overlong <= 1'b1;
        end else begin
          pat <= {pat[3:0], (cnt >= DASH_MIN)};
          len <= len + 3'd1;
        end
      end

      if (char_end)      pending <= 1'b1;
      else if (word_end) pending <= 1'b0;
    end
  end

  // Output holding register with single-entry handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_valid <= 1'b0;
      char_code  <= 8'h00;
      sym_err    <= 1'b0;
      overflow   <= 1'b0;
    end else if (complete) begin
      if (!char_valid || char_ready) begin
        char_valid <= 1'b1;
        char_code  <= new_code;
        sym_err    <= new_err;
      end else begin
        overflow <= 1'b1;
      end
    end else if (char_valid && char_ready) begin
      char_valid <= 1'b0;
    end
  end

`ifdef MORSE_LED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_dot  <= 1'b0;
      led_dash <= 1'b0;
    end else if (elem_end) begin
      led_dot  <= (cnt < DASH_MIN);
      led_dash <= (cnt >= DASH_MIN);
    end else if (complete || (state_nx == MARK && state != MARK)) begin
      led_dot  <= 1'b0;
      led_dash <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/morse_key_decoder.md
MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 The parameter list SHALL be: TICKS_PER_UNIT, default 8, clk cycles per Morse unit, legal range 1..8191.
REQ-002 The clock port SHALL be: clk  in  1  clock, all logic on rising edge.
REQ-003 The reset port SHALL be: rst  in  1  reset, asynchronous, active-high.
REQ-004 The key input SHALL be: key_in  in  1  synchronised, debounced key level, 1 = mark, 0 = space.
REQ-005 The handshake input SHALL be: char_ready  in  1  consumer accepts char_code when high with char_valid.
REQ-006 The data-valid output SHALL be: char_valid  out  1  char_code holds an undelivered character.
REQ-007 The data output SHALL be: char_code  out  8  ASCII of the decoded character, or 0x20 for a word gap.
REQ-008 The error output SHALL be: sym_err  out  1  the delivered character was an invalid or overlong pattern; qualified by char_valid.
REQ-009 The overflow output SHALL be: overflow  out  1  sticky flag, a character was dropped.

Function
REQ-010 The FSM SHALL have states IDLE, MARK and SPACE, and the block SHALL enter IDLE on reset.
REQ-011 IDLE SHALL go to MARK when key_in=1; SPACE SHALL go to MARK when key_in=1; MARK SHALL go to SPACE when key_in=0.
REQ-012 A 16-bit saturating cycle counter SHALL load 1 on every state entry and increment each cycle the state is held.
REQ-013 On the MARK->SPACE transition, a mark of fewer than 2*TICKS_PER_UNIT cycles SHALL be classed as a dot, and a longer mark as a dash.
REQ-014 The element SHALL shift into a 5-bit pattern register (new element in the LSB, 1 = dash), and the 3-bit length SHALL increment.
REQ-015 If a 6th element arrives, it SHALL set an internal overlong flag; further elements SHALL be ignored until character end.
REQ-016 When the SPACE counter equals 3*TICKS_PER_UNIT and length>0, the block SHALL complete a character: decode it, then clear the pattern, length and overlong flag.
REQ-017 Decoding SHALL cover ITU A-Z (0x41-0x5A) and 0-9 (0x30-0x39); any other pattern, or an overlong one, SHALL yield 0x3F with sym_err=1.
REQ-018 When the SPACE counter equals 7*TICKS_PER_UNIT and at least one character has completed since the last word gap, the block SHALL complete 0x20 with sym_err=0.
REQ-019 After a word gap, the block SHALL return to IDLE.
REQ-020 A completed character SHALL be presented on char_valid/char_code/sym_err in the cycle after completion, and these SHALL be held stable until char_valid&&char_ready.
REQ-021 char_valid SHALL drop in the cycle after acceptance unless a new completion occurs in the same cycle, in which case the new character SHALL load with no gap.
REQ-022 A completion while char_valid=1 and char_ready=0 SHALL discard the new character, keep the old one, and set overflow.
REQ-023 overflow SHALL clear only on reset.
REQ-024 A key_in rise before the 3-unit point SHALL continue the same character.
REQ-025 A key_in rise between the 3-unit and 7-unit points SHALL start a new character with no word gap.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE; clear the counter, pattern, length and flags; and set char_valid=0, char_code=0x00, sym_err=0 and overflow=0.
REQ-027 Reset during a mark SHALL discard the partial character.
REQ-028 After release, key_in already at 1 SHALL start a fresh MARK count in the first clock.

Configuration
REQ-029 Macro MORSE_LED_EN SHALL control the optional outputs led_dot and led_dash (out, 1 bit each).
REQ-030 With MORSE_LED_EN defined, led_dot/led_dash SHALL go high for the last classified element, one-hot, from classification until the next MARK entry or character completion, and SHALL reset to 0.
REQ-031 Without MORSE_LED_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (TICKS_PER_UNIT=4, char_ready=1 unless stated)
REQ-032 The bench SHALL apply key 1 for 4, 0 for 4, 1 for 12, then 0 for 12 -> one char_valid pulse with char_code 0x41, sym_err=0.
REQ-033 The bench SHALL apply a mark of 7 cycles vs 8 cycles, each followed by 12 low -> 0x45 ('E') vs 0x54 ('T').
REQ-034 The bench SHALL apply a single dot, then 28 low cycles -> 0x45 then 0x20, and the block returns to IDLE.
REQ-035 The bench SHALL apply six dots, then 12 low -> 0x3F with sym_err=1.
REQ-036 The bench SHALL apply char_ready=0 and two characters 'E','T' -> 0x45 held, T dropped, overflow=1 until rst.
REQ-037 The bench SHALL assert rst on the 3rd cycle of a mark -> all outputs at reset values, and the next 'E' decodes correctly.
